// File: rtl/touch_led_pkg.sv
// Shared mode encodings, LED patterns and small helpers for the touch-key LED
// mode controller.
package touch_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    localparam logic [1:0] LED_NONE  = 2'b00;
    localparam logic [1:0] LED_BOTH  = 2'b11;
    localparam logic [1:0] LED_ALT_A = 2'b01;
    localparam logic [1:0] LED_ALT_B = 2'b10;

    // Mode reached by a short press.
    function automatic mode_e mode_step(input mode_e m);
        mode_e n;
        n = MODE_OFF;
        case (m)
            MODE_OFF:   n = MODE_ON;
            MODE_ON:    n = MODE_BLINK;
            MODE_BLINK: n = MODE_ALT;
            MODE_ALT:   n = MODE_OFF;
            default:    n = MODE_OFF;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] led_decode(input mode_e m, input logic phase);
        logic [1:0] p;
        p = LED_NONE;
        case (m)
            MODE_OFF:   p = LED_NONE;
            MODE_ON:    p = LED_BOTH;
            MODE_BLINK: p = phase ? LED_NONE : LED_BOTH;
            MODE_ALT:   p = phase ? LED_ALT_B : LED_ALT_A;
            default:    p = LED_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/touch_key_event.sv
// Synchronises the touch key and classifies each touch into a one-cycle
// short-press or long-press pulse.
module touch_key_event
    import touch_led_pkg::*;
#(
    parameter logic [25:0] LONG_PRESS = 26'd49_999_999
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_short_press,
    output logic o_long_press
);

    logic        r_k_s0;
    logic        r_k_s1;
    logic        r_k_d;
    logic [25:0] r_press_cnt;
    logic        r_short_press;
    logic        r_long_press;
    logic        w_fall;
    logic        w_long_hit;

    assign w_fall     = ~r_k_s1 & r_k_d;
    // Fires on the single cycle the counter steps onto the long-press threshold.
    assign w_long_hit = r_k_s1 && (r_press_cnt == (LONG_PRESS - 26'd1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k_s0        <= 1'b0;
            r_k_s1        <= 1'b0;
            r_k_d         <= 1'b0;
            r_press_cnt   <= 26'd0;
            r_short_press <= 1'b0;
            r_long_press  <= 1'b0;
        end else begin
            r_k_s0 <= i_key;
            r_k_s1 <= r_k_s0;
            r_k_d  <= r_k_s1;

            if (!r_k_s1) begin
                r_press_cnt <= 26'd0;
            end else if (r_press_cnt != LONG_PRESS) begin
                r_press_cnt <= r_press_cnt + 26'd1;
            end

            // Releases after the counter saturated were already reported as long.
            r_short_press <= w_fall && (r_press_cnt < LONG_PRESS);
            r_long_press  <= w_long_hit;
        end
    end

    assign o_short_press = r_short_press;
    assign o_long_press  = r_long_press;

endmodule

// File: rtl/touch_led_mode_ctrl.sv
// Touch-key LED mode controller: steps OFF/ON/BLINK/ALT on short presses,
// returns to OFF on a long press, and drives the LEDs from a blink timer.
module touch_led_mode_ctrl
    import touch_led_pkg::*;
#(
    parameter logic [24:0] CNT_MAX    = 25'd24_999_999,
    parameter logic [25:0] LONG_PRESS = 26'd49_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       touch_key,
    output logic [1:0] led,
    output logic [1:0] mode,
    output logic       short_press,
    output logic       long_press
);

    logic        w_short_press;
    logic        w_long_press;
    mode_e       r_mode;
    mode_e       w_mode_next;
    logic        w_mode_change;
    logic        w_blink_run;
    logic [24:0] r_blink_cnt;
    logic        r_phase;

    touch_key_event #(
        .LONG_PRESS (LONG_PRESS)
    ) u_key_event (
        .i_clk         (sys_clk),
        .i_rst_n       (sys_rst_n),
        .i_key         (touch_key),
        .o_short_press (w_short_press),
        .o_long_press  (w_long_press)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode <= MODE_OFF;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (w_long_press) begin
            w_mode_next = MODE_OFF;
        end else if (w_short_press) begin
            w_mode_next = mode_step(r_mode);
        end
    end

    assign w_mode_change = (w_mode_next != r_mode);
    assign w_blink_run   = (r_mode == MODE_BLINK) || (r_mode == MODE_ALT);

    // Clearing on every mode change gives each BLINK/ALT entry a full first half-period.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_blink_cnt <= 25'd0;
            r_phase     <= 1'b0;
        end else if (w_mode_change || !w_blink_run) begin
            r_blink_cnt <= 25'd0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == CNT_MAX) begin
            r_blink_cnt <= 25'd0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 25'd1;
        end
    end

    assign led         = led_decode(r_mode, r_phase);
    assign mode        = r_mode;
    assign short_press = w_short_press;
    assign long_press  = w_long_press;

endmodule

// File: tb/tb_touch_led_mode_ctrl.sv
// Directed self-checking bench for touch_led_mode_ctrl (CNT_MAX=9, LONG_PRESS=50).
module tb_touch_led_mode_ctrl;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       touch_key = 1'b0;
    logic [1:0] led;
    logic [1:0] mode;
    logic       short_press;
    logic       long_press;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   n_short      = 0;
    int   n_long       = 0;
    logic both_seen    = 1'b0;

    touch_led_mode_ctrl #(
        .CNT_MAX    (25'd9),
        .LONG_PRESS (26'd50)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .touch_key   (touch_key),
        .led         (led),
        .mode        (mode),
        .short_press (short_press),
        .long_press  (long_press)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (short_press) n_short <= n_short + 1;
        if (long_press)  n_long  <= n_long + 1;
        if (short_press && long_press) both_seen <= 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "timeout");
    end

    // Drives a press of 'hold' clocks, then checks pulse timing and resulting mode.
    task automatic tap(input int hold, input logic [1:0] exp_mode, input string name);
        int s0;
        s0 = n_short;
        touch_key = 1'b1;
        repeat (hold) @(negedge sys_clk);
        touch_key = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        n_compared++;
        if (short_press !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s early_short: got %b want 0", name, short_press);
        end
        @(negedge sys_clk);
        n_compared++;
        if (short_press !== 1'b1 || long_press !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s short_pulse: got short=%b long=%b want short=1 long=0",
                     name, short_press, long_press);
        end
        @(negedge sys_clk);
        n_compared++;
        if (mode !== exp_mode || short_press !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s mode: got mode=%0d short=%b want mode=%0d short=0",
                     name, mode, short_press, exp_mode);
        end
        n_compared++;
        if (n_short != s0 + 1) begin
            n_mismatched++;
            $display("FAIL %s short_count: got %0d want %0d", name, n_short - s0, 1);
        end
        $display("tap %s hold=%0d mode=%0d led=%b", name, hold, mode, led);
    endtask

    // Holds the key for 'hold' clocks (>= 50): long pulse at hold cycle 50, mode OFF while held.
    task automatic long_hold(input int hold, input string name);
        int s0, l0, bad_long, bad_mode;
        s0 = n_short;
        l0 = n_long;
        bad_long = 0;
        bad_mode = 0;
        touch_key = 1'b1;
        for (int i = 1; i <= hold + 10; i++) begin
            @(negedge sys_clk);
            if (i == hold) touch_key = 1'b0;
            if (long_press !== (i == 52)) bad_long++;
            if (i >= 53 && (mode !== 2'd0 || led !== 2'b00)) bad_mode++;
        end
        n_compared++;
        if (bad_long != 0) begin
            n_mismatched++;
            $display("FAIL %s long_timing: got %0d bad cycles want 0", name, bad_long);
        end
        n_compared++;
        if (bad_mode != 0) begin
            n_mismatched++;
            $display("FAIL %s off_while_held: got %0d bad cycles want 0", name, bad_mode);
        end
        n_compared++;
        if (n_long != l0 + 1 || n_short != s0) begin
            n_mismatched++;
            $display("FAIL %s pulse_counts: got long=%0d short=%0d want long=1 short=0",
                     name, n_long - l0, n_short - s0);
        end
        $display("long_hold %s hold=%0d mode=%0d led=%b", name, hold, mode, led);
    endtask

    task automatic test_reset();
        int bad;
        sys_rst_n = 1'b0;
        touch_key = 1'b0;
        repeat (10) @(negedge sys_clk);
        n_compared++;
        if (led !== 2'b00 || mode !== 2'd0 || short_press !== 1'b0 || long_press !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_state: got led=%b mode=%0d s=%b l=%b want 00 0 0 0",
                     led, mode, short_press, long_press);
        end
        sys_rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (led !== 2'b00 || mode !== 2'd0 || short_press !== 1'b0 || long_press !== 1'b0)
                bad++;
        end
        n_compared++;
        if (bad != 0 || n_short != 0 || n_long != 0) begin
            n_mismatched++;
            $display("FAIL idle: got bad=%0d short=%0d long=%0d want 0 0 0", bad, n_short, n_long);
        end
        $display("test_reset done led=%b mode=%0d", led, mode);
    endtask

    task automatic test_short_press();
        int bad;
        tap(20, 2'd1, "off_to_on");
        bad = 0;
        repeat (30) begin
            if (led !== 2'b11) bad++;
            @(negedge sys_clk);
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("FAIL on_steady: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_blink();
        int bad;
        logic [1:0] exp;
        tap(20, 2'd2, "on_to_blink");
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            exp = (((i / 10) % 2) == 0) ? 2'b11 : 2'b00;
            if (led !== exp) bad++;
            @(negedge sys_clk);
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("FAIL blink_pattern: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_alt();
        int bad;
        logic [1:0] exp;
        tap(20, 2'd3, "blink_to_alt");
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            exp = (((i / 10) % 2) == 0) ? 2'b01 : 2'b10;
            if (led !== exp) bad++;
            @(negedge sys_clk);
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("FAIL alt_pattern: got %0d bad cycles want 0", bad);
        end
        tap(20, 2'd0, "alt_to_off");
        bad = 0;
        repeat (25) begin
            if (led !== 2'b00) bad++;
            @(negedge sys_clk);
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("FAIL off_steady: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_long_press();
        int l0;
        tap(20, 2'd1, "lp_on");
        tap(20, 2'd2, "lp_blink");
        tap(20, 2'd3, "lp_alt");
        long_hold(80, "alt_long80");
        l0 = n_long;
        tap(49, 2'd1, "hold49_short");
        tap(1, 2'd2, "hold1_short");
        n_compared++;
        if (n_long != l0) begin
            n_mismatched++;
            $display("FAIL short_holds_no_long: got %0d want 0", n_long - l0);
        end
        long_hold(50, "blink_long50");
    endtask

    task automatic test_reset_mid();
        tap(20, 2'd1, "rm_on");
        tap(20, 2'd2, "rm_blink");
        repeat (12) @(negedge sys_clk);
        n_compared++;
        if (led !== 2'b00) begin
            n_mismatched++;
            $display("FAIL blink_phase1: got %b want 00", led);
        end
        #5;
        sys_rst_n = 1'b0;
        touch_key = 1'b1;
        #1;
        n_compared++;
        if (led !== 2'b00 || mode !== 2'd0) begin
            n_mismatched++;
            $display("FAIL async_reset: got led=%b mode=%0d want 00 0", led, mode);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tap(20, 2'd1, "held_across_reset");
    endtask

    task automatic test_exclusive();
        n_compared++;
        if (both_seen !== 1'b0) begin
            n_mismatched++;
            $display("FAIL pulses_exclusive: got both_seen=%b want 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_blink();
        test_alt();
        test_long_press();
        test_reset_mid();
        repeat (5) @(negedge sys_clk);
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/touch_led_mode_ctrl.md
Name: touch_led_mode_ctrl

Overview:
Mode controller that sequences the two board LEDs from a single capacitive touch key. It classifies each touch as a short or long press and steps a 4-state LED mode machine. It drives the LED pattern with a programmable blink timer. It sits between the touch-key pad and the led[1:0] pins, above the simple touch/LED toggle logic.

Parameters:
CNT_MAX, 25'd24_999_999, blink half-period minus 1 in clocks (0.5 s at 50 MHz); phase toggles every CNT_MAX+1 clocks.
LONG_PRESS, 26'd49_999_999, hold length in clocks that qualifies as a long press (1 s at 50 MHz); must be > 1.

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
touch_key  input  1  touch IC output, 1 = touched, asynchronous to sys_clk
led  output  2  LED drive, 1 = lit
mode  output  2  current mode: 0 OFF, 1 ON, 2 BLINK, 3 ALT
short_press  output  1  one-cycle pulse per short press
long_press  output  1  one-cycle pulse per long press

Behaviour:
- Reset: one clock, asynchronous active-low reset (sys_rst_n), all flops cleared. Outputs during and after reset: led=00, mode=0, short_press=0, long_press=0.
- Synchronizer: touch_key passes through 2 flops (k_s0, k_s1). k_d is k_s1 delayed one cycle.
  - Fall = ~k_s1 & k_d.
  - Net latency: touch_key low sampled at edge E0; short_press is high in the cycle after E2; mode changes at E3.
- Press counter press_cnt:
  - Cleared to 0 whenever k_s1=0.
  - Increments each cycle k_s1=1, saturating at LONG_PRESS.
- long_press: registered pulse, high for exactly one cycle when press_cnt goes from LONG_PRESS-1 to LONG_PRESS while k_s1=1. It fires while the key is still held.
- short_press: registered pulse on Fall when press_cnt < LONG_PRESS.
  - A release after a long press generates nothing.
  - short_press and long_press are never high together.
- A key already held at reset release counts as a press starting at the first cycle k_s1=1. No rising edge is required.
- Mode FSM, updated on the cycle after a pulse:
  - short_press: OFF→ON→BLINK→ALT→OFF.
  - long_press: any state→OFF, including OFF→OFF.
- Blink timer blink_cnt:
  - Runs only in BLINK and ALT.
  - Counts 0..CNT_MAX. On reaching CNT_MAX it wraps to 0 and toggles phase.
  - blink_cnt=0 and phase=0 in OFF/ON and on every cycle where mode changes. Each BLINK/ALT entry therefore starts a fresh full half-period at phase 0.
- LED decode is combinational from the registered mode and phase, with no extra stage:
  - OFF: 00
  - ON: 11
  - BLINK: phase0 → 11, phase1 → 00
  - ALT: phase0 → 01, phase1 → 10
- Reset asserted mid-operation: led=00 immediately (asynchronous). Any press in progress is discarded.
- Width rule: press_cnt is 26 bits and blink_cnt is 25 bits. Comparisons are unsigned, with no overflow past saturation.

Decomposition:
- Shared package/include touch_led_pkg:
  - mode encodings MODE_OFF/ON/BLINK/ALT (2-bit)
  - LED pattern constants
- Sub-module touch_key_event:
  - Contains the 2-flop sync, edge detect, press_cnt, and the short/long pulse generation, parameterised by LONG_PRESS.
  - The top level holds the mode FSM, blink timer and LED decode.

Test Plan:
(Bench: CNT_MAX=9, LONG_PRESS=50, 20 ns clock.)
1. Reset low 10 cycles, key low, release reset, idle 100 cycles → led=00, mode=0, no pulses throughout.
2. Key high 20 cycles then low → exactly one short_press pulse (3rd cycle after low is sampled), no long_press, mode 0→1, led=11 steady.
3. Second 20-cycle press → mode=2; led=11 for 10 cycles, 00 for 10, periodic at 20 cycles. Check the first half-period is a full 10 cycles.
4. Third press → mode=3, led 01 ×10 cycles then 10 ×10 repeating. Fourth press → mode=0, led=00, blink timer idle.
5. From ALT, hold key 80 cycles → long_press pulse once at hold cycle 50, mode=0 and led=00 while still held. Release gives no short_press. Also check a 49-cycle hold gives short_press only, and a 1-cycle touch gives short_press.
6. In BLINK with phase1, assert reset → led=00 immediately, mode=0. Hold key high across reset release for 20 cycles, then release → one short_press, mode=1.
